// File: rtl/hazard_scoreboard.sv
// Pipeline hazard unit for the 5-stage MIPS core.
// A per-register latency scoreboard decides D-stage stalls; the unit also
// drives E-stage/JR operand forwarding, flushes, and a stall-cycle counter.
module hazard_scoreboard #(
    parameter int NUM_REGS = 32,
    parameter int REG_AW   = 5,
    parameter int LOAD_LAT = 1,
    parameter int MDU_LAT  = 3,
    parameter int PERF_W   = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] rs_D,
    input  logic [REG_AW-1:0] rt_D,
    input  logic              use_rs_D,
    input  logic              use_rt_D,
    input  logic              is_jr_D,
    input  logic              reg_wr_D,
    input  logic [REG_AW-1:0] wr_reg_D,
    input  logic [1:0]        lat_sel_D,
    input  logic [REG_AW-1:0] rs_E,
    input  logic [REG_AW-1:0] rt_E,
    input  logic              reg_wr_E,
    input  logic              reg_wr_M,
    input  logic              reg_wr_W,
    input  logic [REG_AW-1:0] wr_reg_E,
    input  logic [REG_AW-1:0] wr_reg_M,
    input  logic [REG_AW-1:0] wr_reg_W,
    input  logic              mdu_busy_E,
    input  logic              flush_exception_M,
    input  logic              flush_pred_failed_E,
    input  logic              flush_jump_conflict_E,
    output logic              stall_F,
    output logic              stall_D,
    output logic              stall_E,
    output logic              stall_M,
    output logic              stall_W,
    output logic              flush_F,
    output logic              flush_D,
    output logic              flush_E,
    output logic              flush_M,
    output logic              flush_W,
    output logic [1:0]        fw_0_E,
    output logic [1:0]        fw_1_E,
    output logic [1:0]        fw_jr_D,
    output logic [PERF_W-1:0] stall_cycles
);

    // Counter width covers the larger of the two latencies so a long load
    // latency can never be truncated by a short MDU latency.
    localparam int MAX_LAT = (MDU_LAT > LOAD_LAT) ? MDU_LAT : LOAD_LAT;
    localparam int CW      = $clog2(MAX_LAT + 1);

    localparam logic [1:0] SEL_RF = 2'b00;
    localparam logic [1:0] SEL_M  = 2'b01;
    localparam logic [1:0] SEL_W  = 2'b10;

    // Entry 0 exists only so register numbers index directly; it stays zero.
    logic [CW-1:0] cnt [NUM_REGS];

    logic [CW-1:0] issue_lat;
    logic          issue;
    logic          raw;
    logic          jr_raw;
    logic          dstall;

    // Pick M over W when both write the source; register 0 never forwards.
    function automatic logic [1:0] fwd_sel(
        input logic [REG_AW-1:0] src,
        input logic              wr_m,
        input logic [REG_AW-1:0] dst_m,
        input logic              wr_w,
        input logic [REG_AW-1:0] dst_w
    );
        logic [1:0] sel;
        sel = SEL_RF;
        if (src != '0) begin
            if (wr_m && (dst_m == src))
                sel = SEL_M;
            else if (wr_w && (dst_w == src))
                sel = SEL_W;
        end
        return sel;
    endfunction

    // Producer latency by class; the reserved class behaves like the ALU.
    always_comb begin
        issue_lat = '0;
        case (lat_sel_D)
            2'b01:   issue_lat = CW'(LOAD_LAT);
            2'b10:   issue_lat = CW'(MDU_LAT);
            default: issue_lat = '0;
        endcase
    end

    // Hazard detection, stall/flush generation and forwarding selects.
    always_comb begin
        raw = (use_rs_D && (rs_D != '0) && (cnt[rs_D] != '0)) ||
              (use_rt_D && (rt_D != '0) && (cnt[rt_D] != '0));
        jr_raw = is_jr_D && (rs_D != '0) &&
                 ((reg_wr_E && (wr_reg_E == rs_D)) || (cnt[rs_D] != '0));
        dstall = raw || jr_raw;

        stall_F = !flush_exception_M && (mdu_busy_E || dstall);
        stall_D = mdu_busy_E || dstall;
        stall_E = mdu_busy_E;
        stall_M = 1'b0;
        stall_W = 1'b0;

        flush_F = 1'b0;
        flush_D = flush_exception_M || flush_pred_failed_E || flush_jump_conflict_E;
        flush_E = flush_exception_M || flush_pred_failed_E || (dstall && !mdu_busy_E);
        flush_M = flush_exception_M;
        flush_W = 1'b0;

        fw_0_E  = fwd_sel(rs_E, reg_wr_M, wr_reg_M, reg_wr_W, wr_reg_W);
        fw_1_E  = fwd_sel(rt_E, reg_wr_M, wr_reg_M, reg_wr_W, wr_reg_W);
        fw_jr_D = is_jr_D ? fwd_sel(rs_D, reg_wr_M, wr_reg_M, reg_wr_W, wr_reg_W) : SEL_RF;

        issue = reg_wr_D && (wr_reg_D != '0) && !stall_D && !flush_D;
    end

    // Scoreboard update: exception clears, MDU busy freezes, otherwise
    // counters tick down and a newly issued producer overwrites its entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < NUM_REGS; r++)
                cnt[r] <= '0;
        end else if (flush_exception_M) begin
            for (int r = 0; r < NUM_REGS; r++)
                cnt[r] <= '0;
        end else if (!mdu_busy_E) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                if (r == 0)
                    cnt[r] <= '0;
                else if (issue && (wr_reg_D == REG_AW'(r)))
                    cnt[r] <= issue_lat;
                else if (cnt[r] != '0)
                    cnt[r] <= cnt[r] - CW'(1);
            end
        end
    end

    // Performance counter of D-stage stall cycles, wrapping naturally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            stall_cycles <= '0;
        else if (stall_D)
            stall_cycles <= stall_cycles + PERF_W'(1);
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed self-checking bench for hazard_scoreboard. Two instances share
// inputs: "a" uses default parameters, "b" uses LOAD_LAT=3 and a 2-bit
// stall counter so that counter wrap is exercised.
module tb_hazard_scoreboard;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [4:0] rs_D, rt_D, wr_reg_D, rs_E, rt_E, wr_reg_E, wr_reg_M, wr_reg_W;
    logic       use_rs_D, use_rt_D, is_jr_D, reg_wr_D;
    logic [1:0] lat_sel_D;
    logic       reg_wr_E, reg_wr_M, reg_wr_W, mdu_busy_E;
    logic       flush_exception_M, flush_pred_failed_E, flush_jump_conflict_E;

    logic        a_stall_F, a_stall_D, a_stall_E, a_stall_M, a_stall_W;
    logic        a_flush_F, a_flush_D, a_flush_E, a_flush_M, a_flush_W;
    logic [1:0]  a_fw_0_E, a_fw_1_E, a_fw_jr_D;
    logic [31:0] a_stall_cycles;

    logic        b_stall_F, b_stall_D, b_stall_E, b_stall_M, b_stall_W;
    logic        b_flush_F, b_flush_D, b_flush_E, b_flush_M, b_flush_W;
    logic [1:0]  b_fw_0_E, b_fw_1_E, b_fw_jr_D;
    logic [1:0]  b_stall_cycles;

    int errors = 0;
    int checks = 0;
    int exp_cyc_a = 0;
    int exp_cyc_b = 0;

    hazard_scoreboard dut_a (
        .clk(clk), .rst(rst), .rs_D(rs_D), .rt_D(rt_D),
        .use_rs_D(use_rs_D), .use_rt_D(use_rt_D), .is_jr_D(is_jr_D),
        .reg_wr_D(reg_wr_D), .wr_reg_D(wr_reg_D), .lat_sel_D(lat_sel_D),
        .rs_E(rs_E), .rt_E(rt_E), .reg_wr_E(reg_wr_E), .reg_wr_M(reg_wr_M),
        .reg_wr_W(reg_wr_W), .wr_reg_E(wr_reg_E), .wr_reg_M(wr_reg_M),
        .wr_reg_W(wr_reg_W), .mdu_busy_E(mdu_busy_E),
        .flush_exception_M(flush_exception_M),
        .flush_pred_failed_E(flush_pred_failed_E),
        .flush_jump_conflict_E(flush_jump_conflict_E),
        .stall_F(a_stall_F), .stall_D(a_stall_D), .stall_E(a_stall_E),
        .stall_M(a_stall_M), .stall_W(a_stall_W),
        .flush_F(a_flush_F), .flush_D(a_flush_D), .flush_E(a_flush_E),
        .flush_M(a_flush_M), .flush_W(a_flush_W),
        .fw_0_E(a_fw_0_E), .fw_1_E(a_fw_1_E), .fw_jr_D(a_fw_jr_D),
        .stall_cycles(a_stall_cycles)
    );

    hazard_scoreboard #(.LOAD_LAT(3), .PERF_W(2)) dut_b (
        .clk(clk), .rst(rst), .rs_D(rs_D), .rt_D(rt_D),
        .use_rs_D(use_rs_D), .use_rt_D(use_rt_D), .is_jr_D(is_jr_D),
        .reg_wr_D(reg_wr_D), .wr_reg_D(wr_reg_D), .lat_sel_D(lat_sel_D),
        .rs_E(rs_E), .rt_E(rt_E), .reg_wr_E(reg_wr_E), .reg_wr_M(reg_wr_M),
        .reg_wr_W(reg_wr_W), .wr_reg_E(wr_reg_E), .wr_reg_M(wr_reg_M),
        .wr_reg_W(wr_reg_W), .mdu_busy_E(mdu_busy_E),
        .flush_exception_M(flush_exception_M),
        .flush_pred_failed_E(flush_pred_failed_E),
        .flush_jump_conflict_E(flush_jump_conflict_E),
        .stall_F(b_stall_F), .stall_D(b_stall_D), .stall_E(b_stall_E),
        .stall_M(b_stall_M), .stall_W(b_stall_W),
        .flush_F(b_flush_F), .flush_D(b_flush_D), .flush_E(b_flush_E),
        .flush_M(b_flush_M), .flush_W(b_flush_W),
        .fw_0_E(b_fw_0_E), .fw_1_E(b_fw_1_E), .fw_jr_D(b_fw_jr_D),
        .stall_cycles(b_stall_cycles)
    );

    always #5 clk = ~clk;

    task automatic clear_inputs();
        rs_D = '0; rt_D = '0; wr_reg_D = '0; rs_E = '0; rt_E = '0;
        wr_reg_E = '0; wr_reg_M = '0; wr_reg_W = '0;
        use_rs_D = 0; use_rt_D = 0; is_jr_D = 0; reg_wr_D = 0; lat_sel_D = '0;
        reg_wr_E = 0; reg_wr_M = 0; reg_wr_W = 0; mdu_busy_E = 0;
        flush_exception_M = 0; flush_pred_failed_E = 0; flush_jump_conflict_E = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [15:0] a_out, b_out;
        clear_inputs();
        rst = 1'b1;
        #2;
        a_out = {a_stall_F, a_stall_D, a_stall_E, a_stall_M, a_stall_W,
                 a_flush_F, a_flush_D, a_flush_E, a_flush_M, a_flush_W,
                 a_fw_0_E, a_fw_1_E, a_fw_jr_D};
        b_out = {b_stall_F, b_stall_D, b_stall_E, b_stall_M, b_stall_W,
                 b_flush_F, b_flush_D, b_flush_E, b_flush_M, b_flush_W,
                 b_fw_0_E, b_fw_1_E, b_fw_jr_D};
        checks++; if (a_out !== 16'h0) begin errors++; $display("[TB] FAIL reset_outs_a: got %h want 0000", a_out); end
        checks++; if (b_out !== 16'h0) begin errors++; $display("[TB] FAIL reset_outs_b: got %h want 0000", b_out); end
        checks++; if (a_stall_cycles !== 32'd0) begin errors++; $display("[TB] FAIL reset_cyc_a: got %0d want 0", a_stall_cycles); end
        checks++; if (b_stall_cycles !== 2'd0) begin errors++; $display("[TB] FAIL reset_cyc_b: got %0d want 0", b_stall_cycles); end
        @(negedge clk);
        rst = 1'b0;
        tick();
    endtask

    task automatic test_load_use();
        logic [3:0] exp_a, exp_b;
        exp_a = 4'b0001;
        exp_b = 4'b0111;
        clear_inputs();
        reg_wr_D = 1; wr_reg_D = 5'd8; lat_sel_D = 2'b01;
        #1;
        checks++; if (a_stall_D !== 1'b0) begin errors++; $display("[TB] FAIL lw_issue_nostall: got %b want 0", a_stall_D); end
        tick();
        clear_inputs();
        use_rs_D = 1; rs_D = 5'd8;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++; if (a_stall_D !== exp_a[i]) begin errors++; $display("[TB] FAIL lu_stall_a[%0d]: got %b want %b", i, a_stall_D, exp_a[i]); end
            checks++; if (a_flush_E !== exp_a[i]) begin errors++; $display("[TB] FAIL lu_bubble_a[%0d]: got %b want %b", i, a_flush_E, exp_a[i]); end
            checks++; if (a_stall_F !== exp_a[i]) begin errors++; $display("[TB] FAIL lu_stallF_a[%0d]: got %b want %b", i, a_stall_F, exp_a[i]); end
            checks++; if (b_stall_D !== exp_b[i]) begin errors++; $display("[TB] FAIL lu_stall_b[%0d]: got %b want %b", i, b_stall_D, exp_b[i]); end
            checks++; if (b_flush_E !== exp_b[i]) begin errors++; $display("[TB] FAIL lu_bubble_b[%0d]: got %b want %b", i, b_flush_E, exp_b[i]); end
            exp_cyc_a += int'(exp_a[i]);
            exp_cyc_b += int'(exp_b[i]);
            tick();
        end
        clear_inputs();
        reg_wr_M = 1; wr_reg_M = 5'd8; rs_E = 5'd8;
        #1;
        checks++; if (a_fw_0_E !== 2'b01) begin errors++; $display("[TB] FAIL lu_fwd: got %b want 01", a_fw_0_E); end
        checks++; if (a_stall_cycles !== 32'(exp_cyc_a)) begin errors++; $display("[TB] FAIL lu_cyc_a: got %0d want %0d", a_stall_cycles, exp_cyc_a); end
        checks++; if (b_stall_cycles !== 2'(exp_cyc_b)) begin errors++; $display("[TB] FAIL lu_cyc_b: got %0d want %0d", b_stall_cycles, exp_cyc_b % 4); end
        tick();
    endtask

    task automatic test_mdu_hold();
        logic [3:0] exp_rel;
        exp_rel = 4'b0111;
        clear_inputs();
        reg_wr_D = 1; wr_reg_D = 5'd9; lat_sel_D = 2'b10;
        tick();
        clear_inputs();
        use_rt_D = 1; rt_D = 5'd9; mdu_busy_E = 1;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++; if (a_stall_E !== 1'b1) begin errors++; $display("[TB] FAIL mdu_stallE[%0d]: got %b want 1", i, a_stall_E); end
            checks++; if (a_flush_E !== 1'b0) begin errors++; $display("[TB] FAIL mdu_noflushE[%0d]: got %b want 0", i, a_flush_E); end
            checks++; if (a_stall_D !== 1'b1) begin errors++; $display("[TB] FAIL mdu_stallD[%0d]: got %b want 1", i, a_stall_D); end
            exp_cyc_a++;
            exp_cyc_b++;
            tick();
        end
        mdu_busy_E = 0;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++; if (a_stall_D !== exp_rel[i]) begin errors++; $display("[TB] FAIL mdu_rel_a[%0d]: got %b want %b", i, a_stall_D, exp_rel[i]); end
            checks++; if (b_stall_D !== exp_rel[i]) begin errors++; $display("[TB] FAIL mdu_rel_b[%0d]: got %b want %b", i, b_stall_D, exp_rel[i]); end
            checks++; if (a_stall_E !== 1'b0) begin errors++; $display("[TB] FAIL mdu_rel_stallE[%0d]: got %b want 0", i, a_stall_E); end
            exp_cyc_a += int'(exp_rel[i]);
            exp_cyc_b += int'(exp_rel[i]);
            tick();
        end
    endtask

    task automatic test_zero_reg();
        clear_inputs();
        reg_wr_M = 1; wr_reg_M = 5'd0; reg_wr_W = 1; wr_reg_W = 5'd0;
        reg_wr_E = 1; wr_reg_E = 5'd0; is_jr_D = 1; rs_D = 5'd0;
        #1;
        checks++; if (a_fw_0_E !== 2'b00) begin errors++; $display("[TB] FAIL zero_fw0: got %b want 00", a_fw_0_E); end
        checks++; if (a_fw_1_E !== 2'b00) begin errors++; $display("[TB] FAIL zero_fw1: got %b want 00", a_fw_1_E); end
        checks++; if (a_fw_jr_D !== 2'b00) begin errors++; $display("[TB] FAIL zero_fwjr: got %b want 00", a_fw_jr_D); end
        checks++; if (a_stall_D !== 1'b0) begin errors++; $display("[TB] FAIL zero_jr_stall: got %b want 0", a_stall_D); end
        clear_inputs();
        reg_wr_D = 1; wr_reg_D = 5'd0; lat_sel_D = 2'b10;
        tick();
        clear_inputs();
        use_rs_D = 1; use_rt_D = 1;
        #1;
        checks++; if (a_stall_D !== 1'b0) begin errors++; $display("[TB] FAIL zero_issue_a: got %b want 0", a_stall_D); end
        checks++; if (b_stall_D !== 1'b0) begin errors++; $display("[TB] FAIL zero_issue_b: got %b want 0", b_stall_D); end
        tick();
    endtask

    task automatic test_forwarding();
        clear_inputs();
        rs_E = 5'd5; rt_E = 5'd6;
        reg_wr_M = 1; wr_reg_M = 5'd5; reg_wr_W = 1; wr_reg_W = 5'd6;
        rs_D = 5'd5;
        #1;
        checks++; if (a_fw_0_E !== 2'b01) begin errors++; $display("[TB] FAIL fw_m_rs: got %b want 01", a_fw_0_E); end
        checks++; if (a_fw_1_E !== 2'b10) begin errors++; $display("[TB] FAIL fw_w_rt: got %b want 10", a_fw_1_E); end
        checks++; if (a_fw_jr_D !== 2'b00) begin errors++; $display("[TB] FAIL fw_jr_off: got %b want 00", a_fw_jr_D); end
        rt_E = 5'd5; wr_reg_W = 5'd5;
        #1;
        checks++; if (a_fw_1_E !== 2'b01) begin errors++; $display("[TB] FAIL fw_m_prio: got %b want 01", a_fw_1_E); end
        reg_wr_M = 0;
        #1;
        checks++; if (a_fw_0_E !== 2'b10) begin errors++; $display("[TB] FAIL fw_w_only: got %b want 10", a_fw_0_E); end
        tick();
    endtask

    task automatic test_jr();
        clear_inputs();
        reg_wr_E = 1; wr_reg_E = 5'd31; is_jr_D = 1; rs_D = 5'd31;
        #1;
        checks++; if (a_stall_D !== 1'b1) begin errors++; $display("[TB] FAIL jr_stall: got %b want 1", a_stall_D); end
        checks++; if (a_flush_E !== 1'b1) begin errors++; $display("[TB] FAIL jr_bubble: got %b want 1", a_flush_E); end
        checks++; if (a_fw_jr_D !== 2'b00) begin errors++; $display("[TB] FAIL jr_fw_e: got %b want 00", a_fw_jr_D); end
        exp_cyc_a++;
        exp_cyc_b++;
        tick();
        reg_wr_E = 0; reg_wr_M = 1; wr_reg_M = 5'd31;
        #1;
        checks++; if (a_stall_D !== 1'b0) begin errors++; $display("[TB] FAIL jr_release: got %b want 0", a_stall_D); end
        checks++; if (a_fw_jr_D !== 2'b01) begin errors++; $display("[TB] FAIL jr_fw_m: got %b want 01", a_fw_jr_D); end
        reg_wr_M = 0; reg_wr_W = 1; wr_reg_W = 5'd31;
        #1;
        checks++; if (a_fw_jr_D !== 2'b10) begin errors++; $display("[TB] FAIL jr_fw_w: got %b want 10", a_fw_jr_D); end
        tick();
    endtask

    task automatic test_exception();
        clear_inputs();
        reg_wr_D = 1; wr_reg_D = 5'd8; lat_sel_D = 2'b01;
        tick();
        clear_inputs();
        use_rs_D = 1; rs_D = 5'd8;
        #1;
        checks++; if (a_stall_D !== 1'b1) begin errors++; $display("[TB] FAIL exc_pre_a: got %b want 1", a_stall_D); end
        checks++; if (b_stall_D !== 1'b1) begin errors++; $display("[TB] FAIL exc_pre_b: got %b want 1", b_stall_D); end
        exp_cyc_a++;
        exp_cyc_b++;
        tick();
        flush_exception_M = 1;
        reg_wr_D = 1; wr_reg_D = 5'd10; lat_sel_D = 2'b10;
        #1;
        checks++; if (b_stall_F !== 1'b0) begin errors++; $display("[TB] FAIL exc_stallF: got %b want 0", b_stall_F); end
        checks++; if (b_stall_D !== 1'b1) begin errors++; $display("[TB] FAIL exc_stallD: got %b want 1", b_stall_D); end
        checks++; if ({b_flush_D, b_flush_E, b_flush_M} !== 3'b111) begin errors++; $display("[TB] FAIL exc_flush_b: got %b want 111", {b_flush_D, b_flush_E, b_flush_M}); end
        checks++; if ({a_stall_D, a_flush_D, a_flush_E} !== 3'b011) begin errors++; $display("[TB] FAIL exc_flush_a: got %b want 011", {a_stall_D, a_flush_D, a_flush_E}); end
        exp_cyc_b++;
        tick();
        clear_inputs();
        use_rs_D = 1; rs_D = 5'd8; use_rt_D = 1; rt_D = 5'd10;
        #1;
        checks++; if (b_stall_D !== 1'b0) begin errors++; $display("[TB] FAIL exc_cleared_b: got %b want 0", b_stall_D); end
        checks++; if (a_stall_D !== 1'b0) begin errors++; $display("[TB] FAIL exc_no_issue_a: got %b want 0", a_stall_D); end
        checks++; if (a_stall_cycles !== 32'(exp_cyc_a)) begin errors++; $display("[TB] FAIL cyc_total_a: got %0d want %0d", a_stall_cycles, exp_cyc_a); end
        checks++; if (b_stall_cycles !== 2'(exp_cyc_b)) begin errors++; $display("[TB] FAIL cyc_wrap_b: got %0d want %0d", b_stall_cycles, exp_cyc_b % 4); end
        tick();
    endtask

    task automatic test_reset_mid_stall();
        clear_inputs();
        reg_wr_D = 1; wr_reg_D = 5'd9; lat_sel_D = 2'b10;
        tick();
        clear_inputs();
        use_rs_D = 1; rs_D = 5'd9;
        #1;
        checks++; if (a_stall_D !== 1'b1) begin errors++; $display("[TB] FAIL rst_pre_stall: got %b want 1", a_stall_D); end
        rst = 1'b1;
        #1;
        checks++; if ({a_stall_F, a_stall_D, a_flush_E} !== 3'b000) begin errors++; $display("[TB] FAIL rst_async_outs: got %b want 000", {a_stall_F, a_stall_D, a_flush_E}); end
        checks++; if (a_stall_cycles !== 32'd0) begin errors++; $display("[TB] FAIL rst_async_cyc: got %0d want 0", a_stall_cycles); end
        checks++; if (b_stall_cycles !== 2'd0) begin errors++; $display("[TB] FAIL rst_async_cyc_b: got %0d want 0", b_stall_cycles); end
        @(negedge clk);
        rst = 1'b0;
        clear_inputs();
    endtask

    initial begin
        clear_inputs();
        test_reset();
        test_load_use();
        test_mdu_hold();
        test_zero_reg();
        test_forwarding();
        test_jr();
        test_exception();
        test_reset_mid_stall();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
